// File: rtl/nes_bus_pkg.sv
// Shared 2A03 bus definitions: register addresses decoded on the CPU bus and
// the OAM DMA sequencer state encoding.
package nes_bus_pkg;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          XFER_LEN      = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        ALIGN     = 3'd2,
        READ      = 3'd3,
        WRITE     = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA: a CPU write to $4014 halts the CPU and copies one 256-byte page
// to $2004 as alternating read/write bus cycles, then hands the bus back.
module oam_dma_controller
    import nes_bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        cpu_rdy,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_data_out,
    output logic        dma_active
);

    localparam logic [8:0] LAST_INDEX = 9'(XFER_LEN - 1);

    // Handshake: the CPU is stalled only while cpu_rdy is low on a read cycle,
    // and bus_grant high means the bus mux drives dma_addr/dma_rw/dma_data_out.
    dma_state_t  state_q, state_d;
    logic        parity_q, parity_d;
    logic [8:0]  index_q, index_d;
    logic [7:0]  page_q, page_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        bus_grant_q, bus_grant_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic        dma_rw_q, dma_rw_d;
    logic [7:0]  dma_data_out_q, dma_data_out_d;
    logic        dma_active_q, dma_active_d;
    logic        trig_hit;

    assign trig_hit = !cpu_rw && (cpu_addr == DMA_TRIG_ADDR);

    always_comb begin
        state_d        = state_q;
        parity_d       = ~parity_q;
        index_d        = index_q;
        page_d         = page_q;
        cpu_rdy_d      = cpu_rdy_q;
        bus_grant_d    = bus_grant_q;
        dma_addr_d     = dma_addr_q;
        dma_rw_d       = dma_rw_q;
        dma_data_out_d = dma_data_out_q;
        dma_active_d   = dma_active_q;

        case (state_q)
            IDLE: begin
                if (trig_hit) begin
                    state_d      = HALT_WAIT;
                    page_d       = cpu_data_out;
                    index_d      = '0;
                    cpu_rdy_d    = 1'b0;
                    dma_active_d = 1'b1;
                end
            end
            HALT_WAIT: begin
                // RDY only stalls the CPU on a read, so wait out any write burst.
                if (cpu_rw) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (parity_q) begin
                    state_d     = READ;
                    bus_grant_d = 1'b1;
                    dma_rw_d    = 1'b1;
                    dma_addr_d  = {page_q, index_q[7:0]};
                end
            end
            READ: begin
                state_d        = WRITE;
                dma_data_out_d = bus_data_in;
                dma_rw_d       = 1'b0;
                dma_addr_d     = OAM_DATA_ADDR;
            end
            WRITE: begin
                index_d = index_q + 9'd1;
                if (index_q == LAST_INDEX) begin
                    state_d      = IDLE;
                    cpu_rdy_d    = 1'b1;
                    bus_grant_d  = 1'b0;
                    dma_active_d = 1'b0;
                    dma_rw_d     = 1'b1;
                    dma_addr_d   = '0;
                end else begin
                    state_d    = READ;
                    dma_rw_d   = 1'b1;
                    // Low byte only: the source never carries into the next page.
                    dma_addr_d = {page_q, index_d[7:0]};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            parity_q       <= 1'b0;
            index_q        <= '0;
            page_q         <= '0;
            cpu_rdy_q      <= 1'b1;
            bus_grant_q    <= 1'b0;
            dma_addr_q     <= 16'h0000;
            dma_rw_q       <= 1'b1;
            dma_data_out_q <= 8'h00;
            dma_active_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            parity_q       <= parity_d;
            index_q        <= index_d;
            page_q         <= page_d;
            cpu_rdy_q      <= cpu_rdy_d;
            bus_grant_q    <= bus_grant_d;
            dma_addr_q     <= dma_addr_d;
            dma_rw_q       <= dma_rw_d;
            dma_data_out_q <= dma_data_out_d;
            dma_active_q   <= dma_active_d;
        end
    end

    assign cpu_rdy      = cpu_rdy_q;
    assign bus_grant    = bus_grant_q;
    assign dma_addr     = dma_addr_q;
    assign dma_rw       = dma_rw_q;
    assign dma_data_out = dma_data_out_q;
    assign dma_active   = dma_active_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: table of transfer scenarios plus hand-written
// reset sequences, with a memory model and a bus monitor.
module tb_oam_dma_controller;

    logic        clock;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_out;
    logic [7:0]  bus_data_in;
    logic        cpu_rdy;
    logic        bus_grant;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_data_out;
    logic        dma_active;

    oam_dma_controller dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_data_out (cpu_data_out),
        .bus_data_in  (bus_data_in),
        .cpu_rdy      (cpu_rdy),
        .bus_grant    (bus_grant),
        .dma_addr     (dma_addr),
        .dma_rw       (dma_rw),
        .dma_data_out (dma_data_out),
        .dma_active   (dma_active)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: byte value is a function of its address
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    logic [7:0] mem [0:65535];
    assign bus_data_in = mem[dma_addr];

    // reference parity: cleared by reset, toggles every other edge
    logic tb_par;
    always @(posedge clock) tb_par <= reset ? 1'b0 : ~tb_par;

    int chk_cnt;
    int pass_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // bus monitor (samples on the falling edge)
    logic        mon_en;
    logic [7:0]  mon_page;
    int          low_cnt, act_cnt, grant_cnt, rd_cnt, wr_cnt, rd_bad, wr_bad, zero_hits;
    logic [15:0] last_rd;
    logic        first_grant_seen, first_grant_rw;

    task automatic mon_clear();
        low_cnt = 0; act_cnt = 0; grant_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        rd_bad = 0; wr_bad = 0; zero_hits = 0; last_rd = 16'h0;
        first_grant_seen = 1'b0; first_grant_rw = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (!cpu_rdy) low_cnt++;
            if (dma_active) act_cnt++;
            if (bus_grant) begin
                grant_cnt++;
                if (!first_grant_seen) begin
                    first_grant_seen = 1'b1;
                    first_grant_rw   = dma_rw;
                end
                if (dma_addr == 16'h0000) zero_hits++;
                if (dma_rw) begin
                    if (dma_addr !== {mon_page, 8'(rd_cnt)}) rd_bad++;
                    last_rd = dma_addr;
                    rd_cnt++;
                end else begin
                    if (dma_addr !== 16'h2004) wr_bad++;
                    if (dma_data_out !== mem_val({mon_page, 8'(wr_cnt)})) wr_bad++;
                    wr_cnt++;
                end
            end
        end
    end

    typedef struct {
        string      name;
        logic [7:0] page;
        logic       want_par;
        int         hold;
        int         retrig_idx;
        int         exp_low;
    } case_t;

    case_t cases [5];

    task automatic cpu_idle();
        cpu_rw       = 1'b1;
        cpu_addr     = 16'h8000;
        cpu_data_out = 8'h00;
    endtask

    task automatic cpu_trigger(input logic [7:0] page);
        cpu_rw       = 1'b0;
        cpu_addr     = 16'h4014;
        cpu_data_out = page;
    endtask

    task automatic run_case(input case_t c);
        int  budget;
        bit  retrig_done;
        mon_clear();
        mon_page = c.page;
        mon_en   = 1'b1;
        while (tb_par !== c.want_par) step();
        cpu_trigger(c.page);
        step();
        for (int i = 0; i < c.hold; i++) begin
            cpu_rw   = 1'b0;
            cpu_addr = 16'h0300;
            step();
        end
        cpu_idle();
        budget      = 0;
        retrig_done = 1'b0;
        while (dma_active && budget < 2000) begin
            if (c.retrig_idx >= 0 && !retrig_done && wr_cnt == c.retrig_idx) begin
                cpu_trigger(8'h03);
                step();
                cpu_idle();
                retrig_done = 1'b1;
            end else begin
                step();
            end
            budget++;
        end
        chk({c.name, " done"}, {31'd0, dma_active}, 32'd0);
        step();
        step();
        mon_en = 1'b0;
        chk({c.name, " rdy_low"}, low_cnt, c.exp_low);
        chk({c.name, " active"}, act_cnt, c.exp_low);
        chk({c.name, " grants"}, grant_cnt, 512);
        chk({c.name, " first_grant_rd"}, {31'd0, first_grant_rw}, 32'd1);
        chk({c.name, " reads"}, rd_cnt, 256);
        chk({c.name, " writes"}, wr_cnt, 256);
        chk({c.name, " rd_addr_bad"}, rd_bad, 0);
        chk({c.name, " wr_bad"}, wr_bad, 0);
        chk({c.name, " last_rd"}, {16'd0, last_rd}, {16'd0, c.page, 8'hFF});
        chk({c.name, " zero_hits"}, zero_hits, 0);
        for (int i = 0; i < 4; i++) step();
        chk({c.name, " idle_active"}, {31'd0, dma_active}, 32'd0);
        chk({c.name, " idle_rdy"}, {31'd0, cpu_rdy}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cpu_rdy"}, {31'd0, cpu_rdy}, 32'd1);
        chk({tag, " bus_grant"}, {31'd0, bus_grant}, 32'd0);
        chk({tag, " dma_active"}, {31'd0, dma_active}, 32'd0);
        chk({tag, " dma_rw"}, {31'd0, dma_rw}, 32'd1);
    endtask

    initial begin
        int budget;
        chk_cnt  = 0;
        pass_cnt = 0;
        mon_en   = 1'b0;
        mon_page = 8'h00;
        mon_clear();
        for (int a = 0; a < 65536; a++) mem[a] = mem_val(16'(a));

        //              name        page   par   hold retrig low
        cases[0] = '{"even",      8'h02, 1'b1, 0,   -1,    514};
        cases[1] = '{"odd",       8'h02, 1'b0, 0,   -1,    515};
        cases[2] = '{"defer2",    8'h02, 1'b1, 2,   -1,    516};
        cases[3] = '{"defer1",    8'h02, 1'b0, 1,   -1,    515};
        cases[4] = '{"pageff",    8'hFF, 1'b1, 0,   10,    514};

        reset = 1'b1;
        cpu_idle();
        for (int i = 0; i < 3; i++) step();
        chk_reset_vals("por");
        chk("por dma_addr", {16'd0, dma_addr}, 32'h0);
        chk("por dma_data", {24'd0, dma_data_out}, 32'h0);
        reset = 1'b0;
        step();
        chk_reset_vals("por_rel");

        for (int k = 0; k < 5; k++) run_case(cases[k]);

        // reset mid-transfer at the WRITE of index 0x40
        mon_clear();
        mon_page = 8'h02;
        mon_en   = 1'b1;
        cpu_trigger(8'h02);
        step();
        cpu_idle();
        budget = 0;
        while (!(bus_grant && !dma_rw && wr_cnt == 64) && budget < 2000) begin
            step();
            budget++;
        end
        chk("mid reached_write40", {31'd0, bus_grant && !dma_rw}, 32'd1);
        reset = 1'b1;
        step();
        mon_en = 1'b0;
        chk_reset_vals("mid_rst");
        step();
        step();
        reset = 1'b0;
        step();
        chk_reset_vals("mid_rel");
        chk("mid wr_bad", wr_bad, 0);
        run_case('{"restart", 8'h02, 1'b1, 0, -1, 514});

        // reset wins over a trigger sampled on the same edge
        reset = 1'b1;
        cpu_trigger(8'h02);
        step();
        reset = 1'b0;
        cpu_idle();
        step();
        chk("rst_prio active", {31'd0, dma_active}, 32'd0);
        chk("rst_prio rdy", {31'd0, cpu_rdy}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
